// File: rtl/au_sequencer.sv
// Control and register stage around the arithmetic unit: latches an instruction on Start,
// steps the AU counter through the iterations and accumulates AUOut into R0.
module au_sequencer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Instr,
    input  logic [3:0] Iter,
    input  logic       ClearR0,
    input  logic [4:0] AUOut,
    output logic [2:0] OP,
    output logic [1:0] K,
    output logic [3:0] Counter,
    output logic [4:0] R0Out,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } seqState_t;

    seqState_t  state;
    seqState_t  nextState;
    logic [2:0] opReg;
    logic [1:0] kReg;
    logic [3:0] cntReg;
    logic [3:0] iterReg;
    logic [4:0] r0Reg;
    logic [3:0] iterClamped;

    // The count op never runs its counter past 3.
    assign iterClamped = (Instr[4:2] == 3'b000 && Iter > 4'd3) ? 4'd3 : Iter;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = Start ? EXEC : IDLE;
            EXEC:    nextState = (cntReg == iterReg) ? DONE : EXEC;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        if (state != IDLE) begin
            Busy = 1'b1;
        end
        if (state == DONE) begin
            Done = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            opReg   <= '0;
            kReg    <= '0;
            cntReg  <= '0;
            iterReg <= '0;
            r0Reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opReg   <= Instr[4:2];
                        kReg    <= Instr[1:0];
                        cntReg  <= '0;
                        iterReg <= iterClamped;
                    end else if (ClearR0) begin
                        r0Reg <= '0;
                    end
                end
                EXEC: begin
                    r0Reg <= AUOut;
                    if (cntReg != iterReg) begin
                        cntReg <= cntReg + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign OP      = opReg;
    assign K       = kReg;
    assign Counter = cntReg;
    assign R0Out   = r0Reg;

endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer paired with a small behavioural AU
// (000 count, 001 constant K, 100 add DataIn, 101 subtract DataIn).
module tb_au_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [4:0] Instr;
    logic [3:0] Iter;
    logic       ClearR0;
    logic [4:0] AUOut;
    logic [2:0] OP;
    logic [1:0] K;
    logic [3:0] Counter;
    logic [4:0] R0Out;
    logic       Busy;
    logic       Done;
    logic [4:0] dataIn;

    int unsigned tests = 0;
    int unsigned fails = 0;

    au_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Instr(Instr), .Iter(Iter),
        .ClearR0(ClearR0), .AUOut(AUOut), .OP(OP), .K(K), .Counter(Counter),
        .R0Out(R0Out), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        AUOut = R0Out;
        case (OP)
            3'b000: AUOut = {1'b0, Counter};
            3'b001: AUOut = {3'b000, K};
            3'b100: AUOut = R0Out + dataIn;
            3'b101: AUOut = R0Out - dataIn;
            default: AUOut = R0Out;
        endcase
    end

    typedef struct {
        logic       start;
        logic       clr;
        logic [4:0] instr;
        logic [3:0] iter;
        logic [4:0] data;
        logic [4:0] r0;
        logic [3:0] cnt;
        logic [2:0] op;
        logic [1:0] k;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[21];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        Start   = 1'b0;
        ClearR0 = 1'b0;
    endtask

    initial begin
        int unsigned doneCount;
        int unsigned lastDone;
        int unsigned runIdx;
        logic        gap;

        //            st  clr instr     it  data  | r0  cnt op      k      busy done
        vecs[0]  = '{1'b1, 1'b0, 5'b10000, 4'd2, 5'd5, 5'd0,  4'd0, 3'b100, 2'b00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'b10000, 4'd2, 5'd5, 5'd5,  4'd1, 3'b100, 2'b00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'b10000, 4'd2, 5'd5, 5'd10, 4'd2, 3'b100, 2'b00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'b10000, 4'd2, 5'd5, 5'd15, 4'd2, 3'b100, 2'b00, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'b10000, 4'd2, 5'd5, 5'd15, 4'd2, 3'b100, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'b00000, 4'd9, 5'd5, 5'd15, 4'd0, 3'b000, 2'b00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'b00000, 4'd9, 5'd5, 5'd0,  4'd1, 3'b000, 2'b00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 5'b00000, 4'd9, 5'd5, 5'd1,  4'd2, 3'b000, 2'b00, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'b00000, 4'd9, 5'd5, 5'd2,  4'd3, 3'b000, 2'b00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'b00000, 4'd9, 5'd5, 5'd3,  4'd3, 3'b000, 2'b00, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 5'b00000, 4'd9, 5'd5, 5'd3,  4'd3, 3'b000, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 5'b00110, 4'd0, 5'd5, 5'd3,  4'd0, 3'b001, 2'b10, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'b00110, 4'd0, 5'd5, 5'd2,  4'd0, 3'b001, 2'b10, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'b00110, 4'd0, 5'd5, 5'd2,  4'd0, 3'b001, 2'b10, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 5'b10111, 4'd0, 5'd5, 5'd2,  4'd0, 3'b101, 2'b11, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 5'b10111, 4'd0, 5'd5, 5'd29, 4'd0, 3'b101, 2'b11, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 5'b10111, 4'd0, 5'd5, 5'd29, 4'd0, 3'b101, 2'b11, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 5'b10000, 4'd0, 5'd1, 5'd29, 4'd0, 3'b100, 2'b00, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 5'b10000, 4'd0, 5'd1, 5'd30, 4'd0, 3'b100, 2'b00, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 5'b10000, 4'd0, 5'd1, 5'd30, 4'd0, 3'b100, 2'b00, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 5'b10000, 4'd0, 5'd1, 5'd0,  4'd0, 3'b100, 2'b00, 1'b0, 1'b0};

        Reset = 1'b1;
        idleInputs();
        Instr  = 5'b11111;
        Iter   = 4'd15;
        dataIn = '0;
        #3;
        check("resetState", {R0Out, Counter, OP, K, Busy, Done}, 16'h0000);
        step();
        Reset = 1'b0;
        step();

        for (int i = 0; i < 21; i++) begin
            Start   = vecs[i].start;
            ClearR0 = vecs[i].clr;
            Instr   = vecs[i].instr;
            Iter    = vecs[i].iter;
            dataIn  = vecs[i].data;
            step();
            check($sformatf("vec%0d", i), {R0Out, Counter, OP, K, Busy, Done},
                  {vecs[i].r0, vecs[i].cnt, vecs[i].op, vecs[i].k, vecs[i].busy, vecs[i].done});
        end
        idleInputs();

        // Busy lockout: Start/ClearR0/Instr changes during EXEC must not disturb the run.
        Start = 1'b1; Instr = 5'b10000; Iter = 4'd3; dataIn = 5'd2;
        step();
        Start = 1'b1; ClearR0 = 1'b1; Instr = 5'b00111; Iter = 4'd0;
        step();
        check("lockoutR0", R0Out, 5'd2);
        idleInputs();
        doneCount = 0;
        for (int c = 0; c < 12 && Busy; c++) begin
            if (c == 1) begin
                ClearR0 = 1'b1;
                Start   = 1'b1;
            end else begin
                idleInputs();
            end
            step();
            if (Done) doneCount++;
        end
        idleInputs();
        check("lockoutIdle", Busy, 1'b0);
        check("lockoutDoneCount", doneCount, 1);
        check("lockoutFinal", {R0Out, OP}, {5'd8, 3'b100});
        ClearR0 = 1'b1;
        step();
        ClearR0 = 1'b0;
        check("clearAfterRun", R0Out, 5'd0);

        // Asynchronous reset in the second EXEC cycle.
        Start = 1'b1; Instr = 5'b10000; Iter = 4'd5; dataIn = 5'd3;
        step();
        Start = 1'b0;
        step();
        check("preResetR0", {R0Out, Counter}, {5'd3, 4'd1});
        #2;
        Reset = 1'b1;
        #1;
        check("asyncReset", {R0Out, Counter, OP, K, Busy, Done}, 16'h0000);
        step();
        Reset = 1'b0;
        step();
        Start = 1'b1; Instr = 5'b00101; Iter = 4'd0;
        step();
        Start = 1'b0;
        step();
        check("postResetRun", {R0Out, Busy, Done}, {5'd1, 1'b1, 1'b1});
        step();

        // Back-to-back with Start held high; Instr is poisoned while busy.
        Start = 1'b1; Iter = 4'd0;
        doneCount = 0; lastDone = 0; runIdx = 0; gap = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            Instr = Busy ? 5'b00100 : {3'b001, 2'(runIdx + 1)};
            step();
            if (Done) begin
                check($sformatf("b2bR0_%0d", runIdx), R0Out, runIdx + 1);
                if (doneCount > 0 && c - lastDone != 3) gap = 1'b1;
                doneCount++;
                lastDone = c;
                runIdx   = (runIdx + 1) % 3;
            end
        end
        Start = 1'b0;
        check("b2bDoneCount", doneCount, 3);
        check("b2bSpacing", gap, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
